// File: rtl/radar_pkg.sv
// radar_pkg -- shared types and default widths for the radar sweep scheduler.
//   sweep_state_t : scheduler FSM state encoding
//   DATA_WIDTH_DEF: default width of counters and ACP_CNT
//   AZ_WIDTH_DEF  : default width of the azimuth index
package radar_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int AZ_WIDTH_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ARP = 2'd1,
        ST_ARMED    = 2'd2,
        ST_REQ      = 2'd3
    } sweep_state_t;

    // True in the states where the scheduler is actively tracking a rotation.
    function automatic logic is_running(input sweep_state_t st);
        return (st == ST_ARMED) || (st == ST_REQ);
    endfunction

endpackage

// File: rtl/radar_azimuth_tracker.sv
// radar_azimuth_tracker -- azimuth counter driven by ARP (north) and ACP
// (increment) pulses, plus rotation-consistency checking.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_arp, i_acp      : north pulse, azimuth increment pulse
//   i_check           : enables the ARP consistency check (scheduler running)
//   i_acp_cnt         : measured ACPs per rotation
//   o_az              : current azimuth index
//   o_sync_err_set    : one-cycle pulse, a rotation mismatch was seen this cycle
module radar_azimuth_tracker
    import radar_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int AZ_WIDTH   = AZ_WIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_arp,
    input  logic                  i_acp,
    input  logic                  i_check,
    input  logic [DATA_WIDTH-1:0] i_acp_cnt,
    output logic [AZ_WIDTH-1:0]   o_az,
    output logic                  o_sync_err_set
);

    logic [AZ_WIDTH-1:0]   r_az;
    logic [DATA_WIDTH-1:0] w_az_ext;
    logic [DATA_WIDTH-1:0] w_last;
    logic                  w_at_last;
    logic                  w_wrap;
    logic                  w_arp_err;

    assign w_az_ext  = DATA_WIDTH'(r_az);
    assign w_last    = i_acp_cnt - DATA_WIDTH'(1);
    assign w_at_last = (w_az_ext == w_last);

    // An ACP past the last azimuth without a north pulse means ARP was missed
    // or ACP_CNT is stale.
    assign w_wrap    = i_acp && !i_arp && w_at_last;
    // At north the count must sit on the last azimuth; with a coincident ACP
    // the expected position is 0.
    assign w_arp_err = i_arp && i_check &&
                       (i_acp ? (w_az_ext != '0) : !w_at_last);

    assign o_sync_err_set = w_wrap || w_arp_err;
    assign o_az           = r_az;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_az <= '0;
        end else if (i_arp) begin
            r_az <= i_acp ? AZ_WIDTH'(1) : '0;
        end else if (i_acp) begin
            r_az <= w_at_last ? '0 : r_az + AZ_WIDTH'(1);
        end
    end

endmodule

// File: rtl/radar_sweep_scheduler.sv
// radar_sweep_scheduler -- issues one sweep request per transmit trigger,
// tagged with the azimuth and the trigger ordinal within the rotation.
// Optional feature: define RADAR_SWEEP_SCHED_OVERRUN_CNT_EN to build the
// saturating dropped-trigger counter; otherwise OVERRUN_CNT is tied to 0.
// Ports:
//   S_AXIS_ACLK, S_AXIS_ARESET : clock, asynchronous active-high reset
//   ENABLE, CALIBRATED         : run qualifiers (levels)
//   ARP, ACP, TRIG             : north, azimuth increment, transmit pulses
//   ACP_CNT                    : measured ACPs per rotation
//   SWEEP_REQ/SWEEP_ACK        : request/accept handshake to sweep loader
//   SWEEP_AZ, SWEEP_IDX        : captured azimuth and trigger ordinal
//   RUNNING, SYNC_ERR          : status (ARMED/REQ), sticky rotation error
//   OVERRUN_CNT                : count of triggers dropped while busy
module radar_sweep_scheduler
    import radar_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int AZ_WIDTH   = AZ_WIDTH_DEF
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESET,
    input  logic                  ENABLE,
    input  logic                  CALIBRATED,
    input  logic                  ARP,
    input  logic                  ACP,
    input  logic                  TRIG,
    input  logic [DATA_WIDTH-1:0] ACP_CNT,
    output logic                  SWEEP_REQ,
    input  logic                  SWEEP_ACK,
    output logic [AZ_WIDTH-1:0]   SWEEP_AZ,
    output logic [DATA_WIDTH-1:0] SWEEP_IDX,
    output logic                  RUNNING,
    output logic                  SYNC_ERR,
    output logic [DATA_WIDTH-1:0] OVERRUN_CNT
);

    sweep_state_t          r_state;
    logic                  r_req;
    logic [AZ_WIDTH-1:0]   r_az;
    logic [DATA_WIDTH-1:0] r_idx;
    logic [DATA_WIDTH-1:0] r_trig_cnt;
    logic                  r_sync_err;

    logic                  w_run;
    logic [AZ_WIDTH-1:0]   w_az;
    logic                  w_sync_set;
    logic                  w_sync_clr;
    logic [AZ_WIDTH-1:0]   w_cap_az;
    logic [DATA_WIDTH-1:0] w_idx_base;

    assign w_run = ENABLE && CALIBRATED;

    radar_azimuth_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .AZ_WIDTH   (AZ_WIDTH)
    ) u_az (
        .i_clk          (S_AXIS_ACLK),
        .i_rst          (S_AXIS_ARESET),
        .i_arp          (ARP),
        .i_acp          (ACP),
        .i_check        (is_running(r_state)),
        .i_acp_cnt      (ACP_CNT),
        .o_az           (w_az),
        .o_sync_err_set (w_sync_set)
    );

    // A trigger coincident with north belongs to the new rotation: azimuth 0,
    // ordinal 0, regardless of where the tracker currently sits.
    assign w_cap_az   = ARP ? '0 : w_az;
    assign w_idx_base = ARP ? '0 : r_trig_cnt;
    assign w_sync_clr = (r_state == ST_IDLE) && w_run;

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            r_state    <= ST_IDLE;
            r_req      <= 1'b0;
            r_az       <= '0;
            r_idx      <= '0;
            r_trig_cnt <= '0;
            r_sync_err <= 1'b0;
        end else begin
            // Sticky error; only a fresh start from IDLE clears it.
            if (w_sync_clr)
                r_sync_err <= 1'b0;
            else if (w_sync_set)
                r_sync_err <= 1'b1;

            if (!w_run) begin
                // Abort: request is withdrawn without waiting for ACK.
                r_state    <= ST_IDLE;
                r_req      <= 1'b0;
                r_trig_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state    <= ST_WAIT_ARP;
                        r_trig_cnt <= '0;
                    end
                    ST_WAIT_ARP: begin
                        if (ARP) begin
                            r_state    <= ST_ARMED;
                            r_trig_cnt <= '0;
                        end
                    end
                    ST_ARMED: begin
                        r_trig_cnt <= TRIG ? w_idx_base + DATA_WIDTH'(1) : w_idx_base;
                        if (TRIG) begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                            r_az    <= w_cap_az;
                            r_idx   <= w_idx_base;
                        end
                    end
                    ST_REQ: begin
                        // Ordinal advances even for a dropped trigger.
                        r_trig_cnt <= TRIG ? w_idx_base + DATA_WIDTH'(1) : w_idx_base;
                        if (SWEEP_ACK && TRIG) begin
                            r_az  <= w_cap_az;
                            r_idx <= w_idx_base;
                        end else if (SWEEP_ACK) begin
                            r_state <= ST_ARMED;
                            r_req   <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef RADAR_SWEEP_SCHED_OVERRUN_CNT_EN
    logic [DATA_WIDTH-1:0] r_overrun;
    logic                  w_drop;

    assign w_drop = w_run && (r_state == ST_REQ) && TRIG && !SWEEP_ACK;

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET)
            r_overrun <= '0;
        else if (w_drop && (r_overrun != '1))
            r_overrun <= r_overrun + DATA_WIDTH'(1);
    end

    assign OVERRUN_CNT = r_overrun;
`else
    assign OVERRUN_CNT = '0;
`endif

    assign SWEEP_REQ = r_req;
    assign SWEEP_AZ  = r_az;
    assign SWEEP_IDX = r_idx;
    assign RUNNING   = is_running(r_state);
    assign SYNC_ERR  = r_sync_err;

endmodule

// File: tb/tb_radar_sweep_scheduler.sv
// tb_radar_sweep_scheduler -- directed bench for radar_sweep_scheduler.
// Expected captures are queued when a capturing TRIG is driven and popped
// when the request is observed.
module tb_radar_sweep_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0, cal = 1'b0;
    logic        arp = 1'b0, acp = 1'b0, trig = 1'b0, ack = 1'b0;
    logic [31:0] acp_cnt = 32'd4;
    logic        sweep_req, running, sync_err;
    logic [15:0] sweep_az;
    logic [31:0] sweep_idx, overrun_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] az;
        logic [31:0] idx;
    } cap_t;
    cap_t sb[$];

`ifdef RADAR_SWEEP_SCHED_OVERRUN_CNT_EN
    localparam logic [31:0] OVR3 = 32'd3;
`else
    localparam logic [31:0] OVR3 = 32'd0;
`endif

    always #5 clk = ~clk;

    radar_sweep_scheduler dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .ENABLE        (en),
        .CALIBRATED    (cal),
        .ARP           (arp),
        .ACP           (acp),
        .TRIG          (trig),
        .ACP_CNT       (acp_cnt),
        .SWEEP_REQ     (sweep_req),
        .SWEEP_ACK     (ack),
        .SWEEP_AZ      (sweep_az),
        .SWEEP_IDX     (sweep_idx),
        .RUNNING       (running),
        .SYNC_ERR      (sync_err),
        .OVERRUN_CNT   (overrun_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given pulses; returns at posedge+1 with pulses cleared.
    task automatic cyc(input logic a_arp, input logic a_acp, input logic a_trig, input logic a_ack);
        arp = a_arp; acp = a_acp; trig = a_trig; ack = a_ack;
        @(posedge clk); #1;
        arp = 1'b0; acp = 1'b0; trig = 1'b0; ack = 1'b0;
    endtask

    task automatic push_cap(input logic [15:0] az, input logic [31:0] idx);
        cap_t c;
        c.az = az; c.idx = idx;
        sb.push_back(c);
    endtask

    task automatic chk_cap(input string tag);
        cap_t c;
        chk({tag, "_req"}, 64'(sweep_req), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            c = sb.pop_front();
            chk({tag, "_az"}, 64'(sweep_az), 64'(c.az));
            chk({tag, "_idx"}, 64'(sweep_idx), 64'(c.idx));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 64'(sweep_req), 64'd0);
        chk("rst_az", 64'(sweep_az), 64'd0);
        chk("rst_idx", 64'(sweep_idx), 64'd0);
        chk("rst_run", 64'(running), 64'd0);
        chk("rst_serr", 64'(sync_err), 64'd0);
        chk("rst_ovr", 64'(overrun_cnt), 64'd0);
        rst = 1'b0;

        // Bring-up: ARP, 2 ACPs, TRIG
        en = 1'b1; cal = 1'b1;
        cyc(0, 0, 0, 0);                       // IDLE -> WAIT_ARP
        chk("wait_run", 64'(running), 64'd0);
        cyc(1, 0, 0, 0);                       // -> ARMED, az 0
        chk("armed_run", 64'(running), 64'd1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);                       // az 2
        push_cap(16'd2, 32'd0);
        cyc(0, 0, 1, 0);
        chk_cap("bringup");
        chk("bringup_run", 64'(running), 64'd1);
        chk("bringup_serr", 64'(sync_err), 64'd0);

        // Back-pressure: three TRIGs with ACK low are dropped
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0);
            chk("bp_req", 64'(sweep_req), 64'd1);
            chk("bp_az", 64'(sweep_az), 64'd2);
            chk("bp_idx", 64'(sweep_idx), 64'd0);
        end
        chk("bp_ovr", 64'(overrun_cnt), 64'(OVR3));
        cyc(0, 0, 0, 1);                       // accept, back to ARMED
        chk("bp_ack_req", 64'(sweep_req), 64'd0);
        push_cap(16'd2, 32'd4);
        cyc(0, 0, 1, 0);
        chk_cap("bp_next");

        // Back-to-back: TRIG with ACK keeps REQ high with a new capture
        push_cap(16'd2, 32'd5);
        cyc(0, 0, 1, 1);
        chk_cap("b2b_1");
        push_cap(16'd2, 32'd6);                // azimuth of the TRIG cycle, before ACP
        cyc(0, 1, 1, 1);                       // az -> 3
        chk_cap("b2b_2");
        cyc(0, 0, 0, 1);
        chk("b2b_done_req", 64'(sweep_req), 64'd0);

        // Correct rotation end, then ARP+ACP+TRIG coincidence at azimuth 0
        cyc(1, 0, 0, 0);                       // az 3 == ACP_CNT-1, az -> 0
        chk("rot_ok_serr", 64'(sync_err), 64'd0);
        push_cap(16'd0, 32'd0);
        cyc(1, 1, 1, 0);                       // az -> 1
        chk_cap("coinc");
        chk("coinc_serr", 64'(sync_err), 64'd0);
        cyc(0, 0, 0, 1);
        push_cap(16'd1, 32'd1);                // shows azimuth became 1
        cyc(0, 0, 1, 0);
        chk_cap("coinc_after");
        cyc(0, 0, 0, 1);

        // Sync error: 5 ACPs between ARPs with ACP_CNT=4
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);                       // az 3
        cyc(1, 0, 0, 0);                       // good ARP, az 0
        chk("se_pre_serr", 64'(sync_err), 64'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);                       // az 3
        chk("se_az3_serr", 64'(sync_err), 64'd0);
        cyc(0, 1, 0, 0);                       // wraps to 0
        chk("se_wrap_serr", 64'(sync_err), 64'd1);
        push_cap(16'd0, 32'd0);
        cyc(0, 0, 1, 0);
        chk_cap("se_wrap_az");
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);                       // fifth ACP
        cyc(1, 0, 0, 0);
        chk("se_sticky", 64'(sync_err), 64'd1);
        en = 1'b0;
        cyc(0, 0, 0, 0);                       // -> IDLE
        chk("se_idle_serr", 64'(sync_err), 64'd1);
        chk("se_idle_run", 64'(running), 64'd0);
        en = 1'b1;
        cyc(0, 0, 0, 0);                       // IDLE -> WAIT_ARP clears
        chk("se_clr", 64'(sync_err), 64'd0);

        // Abort: CALIBRATED low in REQ
        cyc(1, 0, 0, 0);
        push_cap(16'd0, 32'd0);
        cyc(0, 0, 1, 0);
        chk_cap("abort_pre");
        cal = 1'b0;
        cyc(0, 0, 0, 0);
        chk("abort_req", 64'(sweep_req), 64'd0);
        chk("abort_run", 64'(running), 64'd0);
        chk("abort_ovr", 64'(overrun_cnt), 64'(OVR3));

        // Reset mid-request
        cal = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        push_cap(16'd1, 32'd0);
        cyc(0, 0, 1, 0);
        chk_cap("rstreq_pre");
        #2 rst = 1'b1;
        #1;
        chk("rstreq_req", 64'(sweep_req), 64'd0);
        chk("rstreq_az", 64'(sweep_az), 64'd0);
        chk("rstreq_idx", 64'(sweep_idx), 64'd0);
        chk("rstreq_run", 64'(running), 64'd0);
        chk("rstreq_serr", 64'(sync_err), 64'd0);
        chk("rstreq_ovr", 64'(overrun_cnt), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/radar_sweep_scheduler.md
RADAR_SWEEP_SCHEDULER -- requirements
Module: radar_sweep_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of counters and ACP_CNT.
REQ-002 SHALL have parameter AZ_WIDTH, default 16, width of the azimuth index.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: S_AXIS_ACLK  in  1  sole clock, all logic on posedge.
REQ-004 SHALL have S_AXIS_ARESET  in  1  asynchronous active-high reset.
REQ-005 SHALL have ENABLE  in  1  software run enable, level.
REQ-006 SHALL have CALIBRATED  in  1  radar period measurements are stable, level.
REQ-007 SHALL have ARP  in  1  north pulse, one cycle wide, synchronous to S_AXIS_ACLK.
REQ-008 SHALL have ACP  in  1  azimuth increment pulse, one cycle wide.
REQ-009 SHALL have TRIG  in  1  transmit-start pulse, one cycle wide.
REQ-010 SHALL have ACP_CNT  in  DATA_WIDTH  measured ACPs per rotation.
REQ-011 SHALL have SWEEP_REQ  out  1  sweep request valid.
REQ-012 SHALL have SWEEP_ACK  in  1  sweep loader ready/accept.
REQ-013 SHALL have SWEEP_AZ  out  AZ_WIDTH  azimuth index captured at TRIG.
REQ-014 SHALL have SWEEP_IDX  out  DATA_WIDTH  TRIG ordinal within the current rotation, starting at 0.
REQ-015 SHALL have RUNNING  out  1  high in states ARMED and REQ.
REQ-016 SHALL have SYNC_ERR  out  1  sticky: azimuth/ACP_CNT mismatch seen.
REQ-017 SHALL have OVERRUN_CNT  out  DATA_WIDTH  count of dropped TRIGs.

Function
REQ-018 SHALL implement states IDLE, WAIT_ARP, ARMED and REQ.
REQ-019 SHALL go IDLE->WAIT_ARP when ENABLE && CALIBRATED, WAIT_ARP->ARMED on ARP, ARMED->REQ on TRIG, and REQ->ARMED on SWEEP_ACK with no TRIG.
REQ-020 SHALL go from any state to IDLE in the next cycle when ENABLE or CALIBRATED is low; SWEEP_REQ drops in that same cycle (abort).
REQ-021 SHALL otherwise hold SWEEP_REQ, SWEEP_AZ and SWEEP_IDX stable from assertion until the cycle of SWEEP_ACK.
REQ-022 SHALL assert SWEEP_REQ in cycle n+1 for a TRIG in cycle n in ARMED, and SHALL set SWEEP_AZ to the azimuth value of cycle n.
REQ-023 SHALL, for TRIG and SWEEP_ACK in the same REQ cycle, stay in REQ with a new capture, giving a back-to-back request with no dead cycle.
REQ-024 SHALL drop a TRIG in REQ without SWEEP_ACK and increment OVERRUN_CNT by 1 (saturating); SWEEP_IDX still advances.
REQ-025 SHALL, on ARP, reset the azimuth to 0, or to 1 when ACP is coincident; otherwise each ACP increments the azimuth by 1.
REQ-026 SHALL wrap the azimuth to 0 when an ACP arrives with azimuth == ACP_CNT-1 and no ARP, and SHALL set SYNC_ERR.
REQ-027 SHALL set SYNC_ERR on ARP in ARMED or REQ when the azimuth != ACP_CNT-1 (or != 0 with coincident ACP).
REQ-028 SHALL reset SWEEP_IDX to 0 on ARP; a TRIG coincident with ARP SHALL be captured with SWEEP_AZ 0 and SWEEP_IDX 0.
REQ-029 SHALL track the azimuth in every state, so that it is valid on entry to ARMED.
REQ-030 SHALL clear SYNC_ERR only on the IDLE->WAIT_ARP transition or on reset.

Reset
REQ-031 SHALL, while S_AXIS_ARESET is high, force: state IDLE, SWEEP_REQ 0, SWEEP_AZ 0, SWEEP_IDX 0, RUNNING 0, SYNC_ERR 0, OVERRUN_CNT 0, azimuth 0.
REQ-032 SHALL let reset assertion mid-request drop SWEEP_REQ immediately (asynchronous), with no ACK required.

Configuration
REQ-033 SHALL, with RADAR_SWEEP_SCHED_OVERRUN_CNT_EN defined, count OVERRUN_CNT per REQ-024; without it, OVERRUN_CNT SHALL be constant 0 and no counter logic SHALL be built; drop behaviour is otherwise identical.

Structure
REQ-034 SHALL take the state enum and AZ_WIDTH/DATA_WIDTH default constants from the shared package radar_pkg.
REQ-035 SHALL place azimuth tracking (REQ-025..027) in sub-module radar_azimuth_tracker; the FSM, capture and counters stay in radar_sweep_scheduler.

Verification
REQ-036 SHALL verify bring-up: ENABLE=1, CALIBRATED=1, ACP_CNT=4, ARP, 2 ACPs, TRIG -> SWEEP_REQ next cycle, SWEEP_AZ=2, SWEEP_IDX=0, RUNNING=1.
REQ-037 SHALL verify back-pressure: SWEEP_ACK held low 3 TRIGs -> REQ outputs stable, OVERRUN_CNT=3, next capture SWEEP_IDX=4.
REQ-038 SHALL verify back-to-back: TRIG coincident with SWEEP_ACK -> SWEEP_REQ stays high, SWEEP_IDX increments by 1 with no gap.
REQ-039 SHALL verify coincidence: ARP+ACP+TRIG in one cycle -> azimuth 1 afterwards, capture SWEEP_AZ=0, SWEEP_IDX=0, SYNC_ERR 0 when the rotation count was correct.
REQ-040 SHALL verify sync error: ACP_CNT=4 with 5 ACPs between ARPs -> azimuth wraps to 0 and SYNC_ERR=1, staying high until re-enable.
REQ-041 SHALL verify abort: CALIBRATED low during REQ -> SWEEP_REQ 0 next cycle, state IDLE; reset mid-REQ -> all outputs 0 immediately.
